// File: rtl/bpt_case1.sv
// Bit-position translator (Case 1): registers a search word and decodes row select,
// bit-position index, significant-length index and Case-1 partition hit.
module bpt_case1 #(
  parameter int unsigned w = 16,
  parameter int unsigned b = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [w-1:0]      in_sword,
  output logic [(2**b)-1:0] data,
  output logic [b-1:0]      BPI,
  output logic [w:0]        LI,
  output logic              in_sw_pre
);

  localparam int unsigned rows  = 2**b;
  localparam int unsigned li_w  = w + 1;
  localparam int unsigned len_w = $clog2(w + 1);

  logic              in_sw_pre_c;
  logic [rows-1:0]   data_c;
  logic [len_w-1:0]  sig_len_c;
  logic [li_w-1:0]   li_c;

  // Next-output decode; the row select is gated off outside the low-order bank.
  always_comb begin
    in_sw_pre_c = 1'b0;
    data_c      = '0;
    sig_len_c   = '0;
    li_c        = '0;

    in_sw_pre_c = (in_sword[w-1:b] == '0);
    if (in_sw_pre_c) begin
      data_c = rows'(1) << in_sword[b-1:0];
    end

    // Ascending scan leaves the position of the highest set bit, plus one.
    for (int i = 0; i < int'(w); i++) begin
      if (in_sword[i]) begin
        sig_len_c = len_w'(i + 1);
      end
    end
    li_c = li_w'(1) << sig_len_c;
  end

  // Output registers; async clear discards any word present during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      BPI       <= '0;
      LI        <= '0;
      in_sw_pre <= 1'b0;
    end else begin
      data      <= data_c;
      BPI       <= in_sword[b-1:0];
      LI        <= li_c;
      in_sw_pre <= in_sw_pre_c;
    end
  end

endmodule

// File: tb/tb_bpt_case1.sv
// Self-checking bench for bpt_case1: directed cases, async reset, random sweep vs model.
module tb_bpt_case1;

  localparam int unsigned W    = 16;
  localparam int unsigned B    = 8;
  localparam int unsigned ROWS = 256;

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      in_sword;
  logic [ROWS-1:0]   data;
  logic [B-1:0]      BPI;
  logic [W:0]        LI;
  logic              in_sw_pre;

  int n_cmp;
  int n_err;

  bpt_case1 #(.w(W), .b(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sword  (in_sword),
    .data      (data),
    .BPI       (BPI),
    .LI        (LI),
    .in_sw_pre (in_sw_pre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: partition test, one-hot row, and significant-length by repeated halving.
  function automatic void model(input logic [W-1:0] wd,
                                output logic [ROWS-1:0] ed, output logic [B-1:0] eb,
                                output logic [W:0] el, output logic ep);
    int unsigned v;
    int unsigned len;
    ep = ((int'(wd) / 256) == 0);
    eb = B'(int'(wd) % 256);
    ed = '0;
    if (ep) ed[int'(wd) % 256] = 1'b1;
    v = int'(wd);
    len = 0;
    while (v != 0) begin
      len++;
      v = v / 2;
    end
    el = '0;
    el[len] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [ROWS-1:0] obs, input logic [ROWS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] wd);
    logic [ROWS-1:0] ed;
    logic [B-1:0]    eb;
    logic [W:0]      el;
    logic            ep;
    model(wd, ed, eb, el, ep);
    chk({tag, ".data"}, data, ed);
    chk({tag, ".BPI"},  ROWS'(BPI), ROWS'(eb));
    chk({tag, ".LI"},   ROWS'(LI), ROWS'(el));
    chk({tag, ".pre"},  ROWS'(in_sw_pre), ROWS'(ep));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"}, data, '0);
    chk({tag, ".BPI"},  ROWS'(BPI), '0);
    chk({tag, ".LI"},   ROWS'(LI), '0);
    chk({tag, ".pre"},  ROWS'(in_sw_pre), '0);
  endtask

  // Drive at the falling edge, check just after the next rising edge.
  task automatic apply(input string tag, input logic [W-1:0] wd);
    @(negedge clk);
    in_sword = wd;
    @(posedge clk);
    #1;
    chk_word(tag, wd);
  endtask

  initial begin
    logic [W-1:0] prev;
    logic [W-1:0] nxt;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_sword = 16'h0000;

    // Reset state
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply("t1_0010", 16'h0010);
    chk("t1_data_exact", data, ROWS'(1) << 16);

    // Async reset between edges must clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_clr");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream
    apply("t2_008a", 16'h008a);
    apply("t2_00fb", 16'h00fb);
    apply("t2_00f1", 16'h00f1);

    // Boundaries
    apply("t3_0000", 16'h0000);
    apply("t3_00ff", 16'h00ff);
    chk("t3_li_bit8", ROWS'(LI), ROWS'(1) << 8);

    // Out-of-partition
    apply("t4_1234", 16'h1234);
    apply("t4_8000", 16'h8000);
    chk("t4_li_bit16", ROWS'(LI), ROWS'(1) << 16);
    apply("t4_0100", 16'h0100);

    // Mid-stream reset; a word seen at an edge during reset is discarded
    apply("t5_008a", 16'h008a);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_clr");
    @(negedge clk);
    in_sword = 16'h00fb;
    @(posedge clk);
    #1;
    chk_zero("t5_hold");
    @(negedge clk);
    rst_n = 1'b1;
    in_sword = 16'h00f1;
    @(posedge clk);
    #1;
    chk_word("t5_00f1", 16'h00f1);

    // Random sweep: check at falling edge after driving the next word (1-cycle alignment)
    prev = 16'h00f1;
    for (int i = 0; i < 10000; i++) begin
      nxt = W'($urandom);
      if (i % 2 == 0) nxt = nxt & W'(($urandom_range(0, 3) == 0) ? 16'hffff : 16'h00ff);
      @(negedge clk);
      in_sword = nxt;
      #1;
      chk_word("rnd", prev);
      chk("rnd_data_pop", ROWS'($countones(data) <= 1), ROWS'(1));
      chk("rnd_li_pop", ROWS'($countones(LI)), ROWS'(1));
      prev = nxt;
    end
    @(posedge clk);
    #1;
    chk_word("rnd_last", prev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
